// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: size codes, FSM states, lane logic.
// Latency: none (pure types, constants and combinational functions).
// Backpressure: not applicable.
package dmem_responder_pkg;

  // Access size encodings as driven by the core's MEM stage
  localparam logic [1:0] MEM_W = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_B = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Misaligned half/word, or the reserved size code
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_W:   return lo != 2'b00;
      MEM_H:   return lo[0];
      MEM_B:   return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Byte lanes touched by a store of the given size at the given byte offset
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      MEM_W:   return 4'b1111;
      MEM_H:   return lo[1] ? 4'b1100 : 4'b0011;
      MEM_B:   return 4'b0001 << lo;
      default: return 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied into every lane so the enables pick the right one
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    case (size)
      MEM_H:   return {2{d[15:0]}};
      MEM_B:   return {4{d[7:0]}};
      default: return d;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word and sign/zero extend it
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] lo,
                                           input logic [1:0] size, input logic lu);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      MEM_H:   return lu ? {16'b0, h} : {{16{h[15]}}, h};
      MEM_B:   return lu ? {24'b0, b} : {{24{b[7]}}, b};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_sram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port; no reset.
// Latency: read data appears one clock after an enabled read; writes land on the same edge.
// Backpressure: none, accepts an access every cycle it is enabled.
module dmem_responder_sram_be #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Byte-masked write or registered read; rdata holds between reads
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder for the core's MEM stage: byte-enabled stores, extended loads, error detect.
// Latency: resp_valid pulses LAT cycles after accept; one request per LAT+1 cycles.
// Backpressure: req_ready is high only in IDLE; inputs are ignored while busy.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_lu,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LAT - 1);

  state_t      state;
  logic [3:0]  cnt;

  // Request latched at accept
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          lu_q;
  logic          we_q;

  // Response-side lane selection, kept apart so the output holds across the next accept
  logic [1:0]  rsp_lo;
  logic [1:0]  rsp_size;
  logic        rsp_lu;
  logic        rsp_zero;

  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [1:0]    cur_size;
  logic          cur_we;
  logic          cur_lu;
  logic          cur_err;
  logic          accept;
  logic          access;
  logic [31:0]   ram_rdata;

  // Address bits above the RAM index alias; they are deliberately dropped
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign accept = req_valid && req_ready;

  // With LAT=1 the access edge is the accept edge, so steer the live request to the RAM
  always_comb begin
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_size  = size_q;
    cur_we    = we_q;
    cur_lu    = lu_q;
    if (state == IDLE) begin
      cur_addr  = req_addr[AW+1:0];
      cur_wdata = req_wdata;
      cur_size  = req_size;
      cur_we    = req_we;
      cur_lu    = req_lu;
    end
  end

  assign access  = (accept && (CNT_LOAD == 4'd0)) || ((state == WAIT) && (cnt == 4'd1));
  assign cur_err = access_err(cur_size, cur_addr[1:0]);

  dmem_responder_sram_be #(.DEPTH(DEPTH), .AW(AW)) u_sram (
    .clk   (clk),
    .en    (access && !cur_err),
    .we    (cur_we),
    .be    (byte_en(cur_size, cur_addr[1:0])),
    .addr  (cur_addr[AW+1:2]),
    .wdata (replicate(cur_size, cur_wdata)),
    .rdata (ram_rdata)
  );

  // Request FSM, latency counter and registered handshake/response flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rsp_zero   <= 1'b1;
      rsp_lo     <= 2'b00;
      rsp_size   <= MEM_W;
      rsp_lu     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      size_q     <= MEM_W;
      lu_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q    <= req_addr[AW+1:0];
            wdata_q   <= req_wdata;
            size_q    <= req_size;
            lu_q      <= req_lu;
            we_q      <= req_we;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
            state     <= (CNT_LOAD == 4'd0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
      if (access) begin
        resp_valid <= 1'b1;
        resp_err   <= cur_err;
        rsp_zero   <= cur_we || cur_err;
        rsp_lo     <= cur_addr[1:0];
        rsp_size   <= cur_size;
        rsp_lu     <= cur_lu;
      end
    end
  end

  // Stores and errors read back as zero; loads extend the registered RAM word
  assign resp_rdata = rsp_zero ? 32'd0 : load_ext(ram_rdata, rsp_lo, rsp_size, rsp_lu);

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized and directed checks of dmem_responder against a byte-array memory model.
// Latency: expects resp_valid exactly LAT cycles after accept.
// Backpressure: drives req_valid only when req_ready, except the held-valid burst.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [1:0]  req_size = 2'b00;
  logic        req_lu = 1'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] mbytes [4096];

  dmem_responder #(.DEPTH(1024), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_size   (req_size),
    .req_lu     (req_lu),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Memory viewed as 4 KiB of bytes, little-endian; updates on stores
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic lu,
                       output logic [31:0] exp_d, output logic exp_e);
    int n;
    logic [31:0] v;
    n = (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    exp_e = (size == 2'b11) || ((addr % n) != 0);
    exp_d = 32'd0;
    if (!exp_e) begin
      if (we) begin
        for (int i = 0; i < n; i++) mbytes[(addr + i) % 4096] = 8'(wdata >> (8 * i));
      end else begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mbytes[(addr + i) % 4096]) << (8 * i));
        if (!lu && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        exp_d = v;
      end
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(n < 20), 32'd1);
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic lu,
                       output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    int          n;
    model(we, addr, wdata, size, lu, exp_d, exp_e);
    wait_ready();
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_size  = size;
    req_lu    = lu;
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    req_addr  = $urandom;
    n = 1;
    while (!resp_valid && n < 20) begin
      check("busy_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    check("latency", n, LAT);
    check("resp_ready", 32'(req_ready), 32'd0);
    check("rdata", resp_rdata, exp_d);
    check("err", 32'(resp_err), 32'(exp_e));
    got_d = resp_rdata;
    got_e = resp_err;
    @(negedge clk);
    check("pulse_end", 32'(resp_valid), 32'd0);
    check("hold_rdata", resp_rdata, got_d);
    check("hold_err", 32'(resp_err), 32'(got_e));
  endtask

  logic [31:0] d, a;
  logic        e;
  logic [1:0]  sz;
  logic [31:0] bb_addr  [4];
  logic [31:0] bb_wdata [4];
  logic [1:0]  bb_size  [4];
  logic        bb_we    [4];
  logic        bb_lu    [4];
  logic [31:0] bb_exp_d [4];
  logic        bb_exp_e [4];
  int          acc_cyc  [4];
  int          acc, rsp, cyc, extra;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(resp_valid), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Preload the 128-byte window used by the random phase
    for (int w = 0; w < 32; w++) issue(1'b1, 32'(w * 4), $urandom, 2'b00, 1'b0, d, e);

    // Word store and load
    issue(1'b1, 32'h40, 32'h1234_5678, 2'b00, 1'b0, d, e);
    issue(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, d, e);
    check("lw_40", d, 32'h1234_5678);

    // Byte and half lanes with extension
    issue(1'b1, 32'h40, 32'h0, 2'b00, 1'b0, d, e);
    issue(1'b1, 32'h41, 32'h80, 2'b10, 1'b0, d, e);
    issue(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, d, e);
    check("sb_word", d, 32'h0000_8000);
    issue(1'b0, 32'h41, 32'h0, 2'b10, 1'b0, d, e);
    check("lb", d, 32'hFFFF_FF80);
    issue(1'b0, 32'h41, 32'h0, 2'b10, 1'b1, d, e);
    check("lbu", d, 32'h0000_0080);
    issue(1'b1, 32'h42, 32'hBEEF, 2'b01, 1'b0, d, e);
    issue(1'b0, 32'h42, 32'h0, 2'b01, 1'b0, d, e);
    check("lh", d, 32'hFFFF_BEEF);
    issue(1'b0, 32'h42, 32'h0, 2'b01, 1'b1, d, e);
    check("lhu", d, 32'h0000_BEEF);

    // Misaligned and reserved size leave RAM untouched
    issue(1'b0, 32'h42, 32'h0, 2'b00, 1'b0, d, e);
    check("lw_mis_err", 32'(e), 32'd1);
    issue(1'b1, 32'h43, 32'h1111, 2'b01, 1'b0, d, e);
    check("sh_mis_err", 32'(e), 32'd1);
    issue(1'b1, 32'h40, 32'h2222_2222, 2'b11, 1'b0, d, e);
    check("size11_err", 32'(e), 32'd1);
    issue(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, d, e);
    check("after_err", d, 32'hBEEF_8000);

    // Address aliasing mod DEPTH words
    issue(1'b1, 32'h1000, 32'hA5A5_A5A5, 2'b00, 1'b0, d, e);
    issue(1'b0, 32'h0000, 32'h0, 2'b00, 1'b0, d, e);
    check("wrap", d, 32'hA5A5_A5A5);

    // Reset mid-WAIT drops a store
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50;
    req_wdata = 32'hDEAD_BEEF; req_size = 2'b00; req_lu = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("midrst_ready", 32'(req_ready), 32'd1);
      check("midrst_valid", 32'(resp_valid), 32'd0);
      check("midrst_rdata", resp_rdata, 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) extra++;
    end
    check("midrst_no_resp", extra, 0);
    issue(1'b0, 32'h50, 32'h0, 2'b00, 1'b0, d, e);

    // req_valid held high across four requests
    bb_we[0] = 1'b1; bb_addr[0] = 32'h60; bb_wdata[0] = $urandom; bb_size[0] = 2'b00; bb_lu[0] = 1'b0;
    bb_we[1] = 1'b0; bb_addr[1] = 32'h60; bb_wdata[1] = 32'h0;    bb_size[1] = 2'b00; bb_lu[1] = 1'b0;
    bb_we[2] = 1'b1; bb_addr[2] = 32'h63; bb_wdata[2] = $urandom; bb_size[2] = 2'b10; bb_lu[2] = 1'b0;
    bb_we[3] = 1'b0; bb_addr[3] = 32'h62; bb_wdata[3] = 32'h0;    bb_size[3] = 2'b01; bb_lu[3] = 1'b0;
    for (int i = 0; i < 4; i++)
      model(bb_we[i], bb_addr[i], bb_wdata[i], bb_size[i], bb_lu[i], bb_exp_d[i], bb_exp_e[i]);
    wait_ready();
    acc = 0; rsp = 0; cyc = 0;
    req_valid = 1'b1; req_we = bb_we[0]; req_addr = bb_addr[0];
    req_wdata = bb_wdata[0]; req_size = bb_size[0]; req_lu = bb_lu[0];
    while ((acc < 4 || rsp < 4) && cyc < 60) begin
      if (resp_valid) begin
        if (rsp < 4) begin
          check("bb_rdata", resp_rdata, bb_exp_d[rsp]);
          check("bb_err", 32'(resp_err), 32'(bb_exp_e[rsp]));
        end
        rsp++;
      end
      if (req_valid && req_ready) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      @(negedge clk);
      cyc++;
      if (acc < 4) begin
        req_we = bb_we[acc]; req_addr = bb_addr[acc];
        req_wdata = bb_wdata[acc]; req_size = bb_size[acc]; req_lu = bb_lu[acc];
      end else begin
        req_valid = 1'b0;
      end
    end
    check("bb_accepts", acc, 4);
    for (int i = 1; i < 4; i++) check("bb_spacing", acc_cyc[i] - acc_cyc[0], 3 * i);
    extra = 0;
    repeat (6) begin
      if (resp_valid) extra++;
      @(negedge clk);
    end
    check("bb_resp_count", rsp + extra, 4);

    // Random mix over the preloaded window, with random aliasing bits
    for (int k = 0; k < 150; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b00) a = a & 32'hFFFF_FFFC;
        if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
      end
      a = ($urandom & 32'hFFFF_F000) | a;
      issue(1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), d, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
